vector_serializer: RTL and testbench
====================================

VECTOR_SERIALIZER -- requirements
Module: vector_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the parallel word width in bits; only 8 is supported.
REQ-002 SHALL have port iClk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port iReset_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port iVector, input, 8, the parallel word to transmit.
REQ-005 SHALL have port iLoad, input, 1, the load request; sampled only when oReady=1.
REQ-006 SHALL have port oReady, output, 1, high when a new word can be accepted.
REQ-007 SHALL have port oSignal, output, 1, the serial data bit.
REQ-008 SHALL have port oValid, output, 1, high while oSignal carries a data or parity bit.
REQ-009 SHALL have port oDone, output, 1, a one-cycle pulse after the final bit of a word.

Function
REQ-010 SHALL implement an FSM with states IDLE, SHIFT, PARITY (present only per REQ-021) and DONE.
REQ-011 IDLE SHALL drive oReady=1, oValid=0, oSignal=0 and oDone=0.
REQ-012 In IDLE with iLoad=1, the block SHALL capture iVector into an 8-bit shift register, clear the bit counter and enter SHIFT on the same edge.
REQ-013 SHIFT SHALL emit bit k of the captured word in its k-th cycle, k=0..7, LSB first, with oValid=1 and oReady=0.
REQ-014 The first bit SHALL appear the cycle after the load edge.
REQ-015 After bit 7, SHIFT SHALL go to PARITY if it is compiled in, otherwise to DONE.
REQ-016 DONE SHALL last exactly one cycle with oDone=1, oValid=0 and oSignal=0, then return to IDLE.
REQ-017 iLoad and iVector SHALL be ignored outside IDLE; the word in flight SHALL NOT be corrupted by changes on iVector.
REQ-018 The 4-bit bit counter SHALL saturate logic at 7 and wrap to 0 only on a load; it SHALL never index past bit 7.
REQ-019 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.
REQ-020 With iLoad held high continuously, words SHALL start every 10 cycles without parity and every 11 cycles with parity.

Configuration
REQ-021 With macro VECTOR_SERIALIZER_PARITY_EN defined, the block SHALL include state PARITY, one cycle long, driving oValid=1 and oSignal set to the even-parity bit (XOR of the 8 captured bits), then going to DONE.
REQ-022 Without VECTOR_SERIALIZER_PARITY_EN, the PARITY state and the parity logic SHALL be absent and SHIFT SHALL go directly to DONE.

Reset
REQ-023 When iReset_n=0 at a rising edge, the block SHALL enter IDLE, clear the shift register and counter, and set oReady=1, oValid=0, oSignal=0 and oDone=0.
REQ-024 Reset SHALL take priority over iLoad.
REQ-025 Reset mid-word SHALL discard the word; no oDone SHALL be produced for it.
REQ-026 The first load after reset release SHALL behave per REQ-012.

Structure
REQ-027 A shared package vector_serializer_pkg SHALL hold the DATA_W constant, the counter width constant (4) and the FSM state enum.
REQ-028 The shift register and bit counter SHALL live in the top module.
REQ-029 One sub-module, vs_parity_gen (8-bit XOR reduction), SHALL be instantiated only under VECTOR_SERIALIZER_PARITY_EN.

Verification
REQ-030 Load 8'hA5 -> oSignal=1,0,1,0,0,1,0,1 on cycles 1..8 after load, oValid=1 for those cycles, oDone=1 on cycle 9 (cycle 10 with parity, parity bit 0).
REQ-031 PARITY_EN build, load 8'h07 -> bits 1,1,1,0,0,0,0,0, then parity bit 1, then oDone pulse; oReady=1 the following cycle.
REQ-032 Load 8'h3C, then pulse iLoad with iVector=8'hFF during SHIFT -> serial output remains 0,0,1,1,1,1,0,0; 8'hFF is never sent.
REQ-033 Load 8'hFF, then iReset_n=0 during bit 3 -> next cycle oValid=0, oSignal=0, oReady=1; no oDone pulse.
REQ-034 iLoad held at 1 with iVector alternating 8'h01/8'h80 -> word starts exactly 10 cycles apart (11 with parity); oDone pulses once per word.
REQ-035 Reset released with iLoad=1 on the same edge -> no load on that edge; load occurs on the next edge.

Source files
------------

// File: rtl/vector_serializer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vector_serializer_pkg
//  Description : Shared constants and FSM state type for vector_serializer.
//                Macro VECTOR_SERIALIZER_PARITY_EN adds the PARITY state.
//  Revision    : 1.0 - initial release
// ============================================================================
package vector_serializer_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    // Index of the last data bit; the counter holds here until the next load
    localparam logic [CNT_W-1:0] LAST_BIT = 4'd7;

`ifdef VECTOR_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd3
    } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/vs_parity_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vs_parity_gen
//  Description : Even-parity bit of an 8-bit word (XOR reduction). Only
//                defined when VECTOR_SERIALIZER_PARITY_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef VECTOR_SERIALIZER_PARITY_EN
module vs_parity_gen (
    input  logic [7:0] data,
    output logic       parity
);

    assign parity = ^data;

endmodule
`endif
`default_nettype wire

// File: rtl/vector_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vector_serializer
//  Description : Captures an 8-bit word and shifts it out LSB first with a
//                valid strobe, an optional even-parity bit and a one-cycle
//                done pulse. Parity enabled by VECTOR_SERIALIZER_PARITY_EN.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_serializer #(
    parameter int DATA_W = vector_serializer_pkg::DATA_W
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic [DATA_W-1:0] iVector,
    input  logic              iLoad,
    output logic              oReady,
    output logic              oSignal,
    output logic              oValid,
    output logic              oDone
);

    import vector_serializer_pkg::*;

    state_t              state;
    state_t              state_nx;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_nx;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic                ready_nx;
    logic                valid_nx;
    logic                signal_nx;
    logic                done_nx;

`ifdef VECTOR_SERIALIZER_PARITY_EN
    logic                parity_bit;

    // The captured word is stable for the whole frame, so parity is taken
    // straight from it when SHIFT hands over to PARITY.
    vs_parity_gen u_parity (
        .data   (shift_reg),
        .parity (parity_bit)
    );
`endif

    // Next-state, datapath and next-output decode; outputs are derived from
    // the next state so they can be registered without adding latency.
    always_comb begin
        state_nx  = state;
        shift_nx  = shift_reg;
        cnt_nx    = bit_cnt;
        ready_nx  = 1'b0;
        valid_nx  = 1'b0;
        signal_nx = 1'b0;
        done_nx   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (iLoad) begin
                    shift_nx = iVector;
                    cnt_nx   = '0;
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Counter stops at the last bit; only a load restarts it
                if (bit_cnt >= LAST_BIT) begin
`ifdef VECTOR_SERIALIZER_PARITY_EN
                    state_nx = ST_PARITY;
`else
                    state_nx = ST_DONE;
`endif
                end else begin
                    cnt_nx = bit_cnt + CNT_W'(1);
                end
            end
`ifdef VECTOR_SERIALIZER_PARITY_EN
            ST_PARITY: state_nx = ST_DONE;
`endif
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase

        case (state_nx)
            ST_IDLE: ready_nx = 1'b1;
            ST_SHIFT: begin
                valid_nx  = 1'b1;
                signal_nx = shift_nx[cnt_nx[2:0]];
            end
`ifdef VECTOR_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                valid_nx  = 1'b1;
                signal_nx = parity_bit;
            end
`endif
            ST_DONE: done_nx  = 1'b1;
            default: ready_nx = 1'b0;
        endcase
    end

    // State, datapath and output registers; reset wins over any load
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            oReady    <= 1'b1;
            oValid    <= 1'b0;
            oSignal   <= 1'b0;
            oDone     <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_reg <= shift_nx;
            bit_cnt   <= cnt_nx;
            oReady    <= ready_nx;
            oValid    <= valid_nx;
            oSignal   <= signal_nx;
            oDone     <= done_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vector_serializer
//  Description : Scoreboard bench for vector_serializer. Stimulus pushes the
//                expected serial bits / done pulse with their cycle numbers;
//                a monitor pops and compares whenever the DUT presents output.
//                Honours VECTOR_SERIALIZER_PARITY_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_serializer;

`ifdef VECTOR_SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int T = 10 + P;   // cycles between word starts

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] vec;
    logic       ready;
    logic       sig;
    logic       valid;
    logic       done;

    always #5 clk = ~clk;

    vector_serializer #(.DATA_W(8)) dut (
        .iClk     (clk),
        .iReset_n (rst_n),
        .iVector  (vec),
        .iLoad    (load),
        .oReady   (ready),
        .oSignal  (sig),
        .oValid   (valid),
        .oDone    (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    typedef struct {
        int cyc;
        bit is_done;
        bit bitv;
    } exp_t;
    exp_t exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Expected frame for a word loaded on edge l: bit k visible in cycle l+k
    task automatic push_word(input logic [7:0] v, input int l, input int nbits, input bit tail);
        exp_t e;
        for (int k = 0; k < nbits; k++) begin
            e.cyc = l + k; e.is_done = 1'b0; e.bitv = v[k];
            exp_q.push_back(e);
        end
        if (tail) begin
            if (P == 1) begin
                e.cyc = l + 8; e.is_done = 1'b0; e.bitv = ^v;
                exp_q.push_back(e);
            end
            e.cyc = l + 8 + P; e.is_done = 1'b1; e.bitv = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("wait_ready", ready, 1);
    endtask

    task automatic send_word(input logic [7:0] v, input int nbits, input bit tail);
        wait_ready();
        load = 1'b1;
        vec  = v;
        push_word(v, cyc + 1, nbits, tail);
        tick();
        load = 1'b0;
    endtask

    // Monitor: compare every presented bit / done pulse against the queue
    always @(negedge clk) begin
        if (started) begin
            if (valid === 1'b1 || done === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output cyc=%0d: got valid=%b done=%b sig=%b, required no output",
                             cyc, valid, done, sig);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || done !== e.is_done || valid !== !e.is_done ||
                        (!e.is_done && sig !== e.bitv)) begin
                        n_err++;
                        $display("FAIL serial_out cyc=%0d: got valid=%b done=%b sig=%b, required cyc=%0d done=%b sig=%b",
                                 cyc, valid, done, sig, e.cyc, e.is_done, e.bitv);
                    end
                end
            end else begin
                n_cmp++;
                if (sig !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_signal cyc=%0d: got %b, required 0", cyc, sig);
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    exp_t m;
                    m = exp_q.pop_front();
                    n_cmp++;
                    n_err++;
                    $display("FAIL missed_output cyc=%0d: got nothing, required done=%b sig=%b at cyc=%0d",
                             cyc, m.is_done, m.bitv, m.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        vec   = 8'h00;
        repeat (3) tick();
        chk("reset_ready",  ready, 1);
        chk("reset_valid",  valid, 0);
        chk("reset_signal", sig,   0);
        chk("reset_done",   done,  0);
        started = 1'b1;
        rst_n   = 1'b1;
        tick();

        // 8'hA5: 1,0,1,0,0,1,0,1 then (parity 0) and done
        send_word(8'hA5, 8, 1'b1);
        repeat (T) tick();

        // 8'h07: 1,1,1,0,0,0,0,0 (parity 1), done, then ready
        send_word(8'h07, 8, 1'b1);
        repeat (8 + P) tick();
        chk("done_pulse",       done,  1);
        chk("busy_at_done",     ready, 0);
        tick();
        chk("ready_after_done", ready, 1);
        chk("done_one_cycle",   done,  0);

        // 8'h3C with a stray load of 8'hFF in the middle of the frame
        send_word(8'h3C, 8, 1'b1);
        tick();
        tick();
        load = 1'b1;
        vec  = 8'hFF;
        tick();
        load = 1'b0;
        vec  = 8'h00;
        chk("busy_in_shift", ready, 0);
        repeat (T) tick();

        // 8'hFF aborted by reset while bit 3 is on the line
        send_word(8'hFF, 4, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_valid",  valid, 0);
        chk("abort_signal", sig,   0);
        chk("abort_ready",  ready, 1);
        chk("abort_done",   done,  0);
        rst_n = 1'b1;
        repeat (T) tick();

        // Load held high across the last reset edge: load happens one edge later
        rst_n = 1'b0;
        load  = 1'b1;
        vec   = 8'h5A;
        tick();
        chk("rst_priority_ready", ready, 1);
        chk("rst_priority_valid", valid, 0);
        rst_n = 1'b1;
        push_word(8'h5A, cyc + 1, 8, 1'b1);
        tick();
        load = 1'b0;
        chk("load_after_release_valid", valid, 1);
        chk("load_after_release_ready", ready, 0);
        repeat (T) tick();

        // Continuous load, alternating 8'h01 / 8'h80: one word every T cycles
        wait_ready();
        begin
            int c0;
            c0   = cyc;
            load = 1'b1;
            for (int i = 0; i < 4; i++) begin
                vec = (i % 2 == 0) ? 8'h01 : 8'h80;
                push_word(vec, c0 + 1 + i * T, 8, 1'b1);
                tick();
                if (i == 3) load = 1'b0;
                repeat (T - 1) tick();
            end
        end

        repeat (5) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
